alu_op_issue: RTL and testbench
===============================

Name: alu_op_issue

Overview:
- Registered ID/EX issue stage that drives the execute ALU's operand and control interface.
- Decodes a 32-bit MIPS instruction plus register-file read values into the ALU's operand A, operand B, 4-bit function code and shift amount, with the destination-register write-back tag.
- Sits between register read and the ALU, with valid/ready handshakes on both sides and a pipeline flush.

Parameters:
- CNT_W, 8, width of the saturating illegal-instruction counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  instruction and operands are valid.
- in_ready  output  1  stage can accept this cycle.
- instr  input  32  MIPS instruction word.
- rs_val  input  32  register value for rs.
- rt_val  input  32  register value for rt.
- flush  input  1  synchronous squash of the held and incoming instruction.
- out_valid  output  1  ALU-side payload is valid.
- out_ready  input  1  execute stage consumes the payload.
- alu_a  output  32  operand A.
- alu_b  output  32  operand B.
- alu_func  output  4  ALU function code.
- alu_shamt  output  5  shift amount.
- dest_reg  output  5  write-back register index.
- reg_write  output  1  result is written back.
- illegal  output  1  issued instruction was undecodable.
- illegal_count  output  CNT_W  saturating count of illegal instructions accepted.

Behaviour:
- Reset (rst_n=0, asynchronous): all of the following are 0: out_valid, alu_a, alu_b, alu_func, alu_shamt, dest_reg, reg_write, illegal, illegal_count.
- Handshake:
  - in_ready = !out_valid | out_ready (combinational).
  - Accept when in_valid & in_ready & !flush. On accept, the payload register loads on the next edge and out_valid=1. Latency is 1 cycle.
  - out_valid & out_ready with no accept in the same cycle: out_valid -> 0.
  - Simultaneous consume and accept: the new payload replaces the old one with no bubble.
  - While out_valid & !out_ready, all outputs hold stable.
- Flush has priority over everything: next edge gives out_valid=0, the incoming instruction is dropped, and illegal_count is not incremented. Payload registers may keep stale values.
- ALU function codes:
  - ADD=0000, SUB=0001, AND=0010, OR=0011, XOR=0100.
  - SLL=0101, SRL=0110, SRA=0111.
  - SLT=1000, SLTU=1001, NOR=1010.
  - SLLV=1011, SRLV=1100, SRAV=1101, LUI=1110.
- Field extraction: op=instr[31:26], rs=[25:21], rt=[20:16], rd=[15:11], sh=[10:6], fn=[5:0], imm=[15:0]; SE = sign-extended imm, ZE = zero-extended imm.
- R-type (op=0x00), a=rs_val, b=rt_val, dest=rd, reg_write=1, shamt=sh:
  - fn 0x20/0x21 ADD; 0x22/0x23 SUB; 0x24 AND; 0x25 OR; 0x26 XOR; 0x27 NOR; 0x2A SLT; 0x2B SLTU.
  - fn 0x00 SLL; 0x02 SRL; 0x03 SRA.
  - fn 0x04 SLLV; 0x06 SRLV; 0x07 SRAV. For these, alu_a = {27'b0, rs_val[4:0]}.
- I-type, a=rs_val, dest=rt, reg_write=1, shamt=0:
  - 0x08/0x09 ADD, b=SE.
  - 0x0A SLT, b=SE; 0x0B SLTU, b=SE.
  - 0x0C AND, b=ZE; 0x0D OR, b=ZE; 0x0E XOR, b=ZE.
  - 0x0F LUI, b=ZE, a=0.
  - 0x23 lw: ADD, b=SE.
- sw (0x2B): ADD, b=SE, reg_write=0, dest=0.
- beq/bne (0x04/0x05): SUB, b=rt_val, reg_write=0, dest=0.
- Any other op/fn is illegal:
  - Outputs: func=ADD, a=b=0, shamt=0, dest=0, reg_write=0, illegal=1.
  - illegal_count increments on accept and saturates at all-ones.
  - The instruction still issues (out_valid=1).
- A write to register 0 is not suppressed here.
- Reset mid-stall: the payload is discarded immediately, and in_ready=1 while rst_n=0.

Test Plan:
- Reset, then instr=0x012A4020 (add $8,$9,$10), rs_val=5, rt_val=7, out_ready=1 -> one cycle later: out_valid=1, alu_a=5, alu_b=7, alu_func=0000, dest_reg=8, reg_write=1, illegal=0.
- instr=0x2128FFFF (addi $8,$9,-1), rs_val=3 -> alu_b=0xFFFFFFFF, alu_func=0000, dest_reg=8. Then instr=0x3528FFFF (ori) -> alu_b=0x0000FFFF, alu_func=0011.
- instr=0x00094083 (sra $8,$9,2) -> alu_func=0111, alu_shamt=2. Then instr=0x01494007 (srav), rs_val=0x23 -> alu_a=3, alu_func=1101.
- out_ready=0 for 3 cycles with a second instruction pending -> in_ready=0 and outputs stable. Raise out_ready -> second payload appears the next cycle with out_valid held at 1 (no bubble).
- flush=1 while out_valid=1 and in_valid=1 with an illegal instr=0xFC000000 -> out_valid=0 next cycle and illegal_count unchanged. Same instr without flush -> illegal=1, reg_write=0, illegal_count=1.
- Issue 256 illegal instructions with CNT_W=8 -> illegal_count stays 0xFF. Assert rst_n=0 mid-stall -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/alu_op_issue.sv
// ID/EX issue stage: decodes a MIPS instruction plus rs/rt values into ALU operands and control.
// Latency: 1 cycle from accept to out_valid. Flush squashes the held and incoming instruction.
// Backpressure: in_ready = !out_valid | out_ready, so the payload holds stable while the ALU stalls.
module alu_op_issue #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [31:0]      rs_val,
  input  logic [31:0]      rt_val,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [3:0]       alu_func,
  output logic [4:0]       alu_shamt,
  output logic [4:0]       dest_reg,
  output logic             reg_write,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_count
);

  localparam logic [3:0] F_ADD  = 4'b0000, F_SUB  = 4'b0001, F_AND  = 4'b0010;
  localparam logic [3:0] F_OR   = 4'b0011, F_XOR  = 4'b0100, F_SLL  = 4'b0101;
  localparam logic [3:0] F_SRL  = 4'b0110, F_SRA  = 4'b0111, F_SLT  = 4'b1000;
  localparam logic [3:0] F_SLTU = 4'b1001, F_NOR  = 4'b1010, F_SLLV = 4'b1011;
  localparam logic [3:0] F_SRLV = 4'b1100, F_SRAV = 4'b1101, F_LUI  = 4'b1110;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  func;
    logic [4:0]  shamt;
    logic [4:0]  dest;
    logic        we;
    logic        ill;
  } payload_t;

  logic [5:0]  op, fn;
  logic [4:0]  rt, rd, sh;
  logic [31:0] imm_se, imm_ze;

  assign op     = instr[31:26];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign sh     = instr[10:6];
  assign fn     = instr[5:0];
  assign imm_se = {{16{instr[15]}}, instr[15:0]};
  assign imm_ze = {16'h0000, instr[15:0]};

  payload_t        dec;
  payload_t        pay_d, pay_q;
  logic            out_valid_d, out_valid_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic            accept;

  assign in_ready = !out_valid_q | out_ready;
  assign accept   = in_valid & in_ready & !flush;

  // Decode the instruction into the ALU payload; undecodable encodings collapse to a zeroed ADD.
  always_comb begin
    dec       = '0;
    dec.a     = rs_val;
    dec.b     = rt_val;
    dec.func  = F_ADD;
    dec.dest  = rt;
    dec.we    = 1'b1;
    unique case (op)
      6'h00: begin
        dec.dest  = rd;
        dec.shamt = sh;
        case (fn)
          6'h20, 6'h21: dec.func = F_ADD;
          6'h22, 6'h23: dec.func = F_SUB;
          6'h24:        dec.func = F_AND;
          6'h25:        dec.func = F_OR;
          6'h26:        dec.func = F_XOR;
          6'h27:        dec.func = F_NOR;
          6'h2A:        dec.func = F_SLT;
          6'h2B:        dec.func = F_SLTU;
          6'h00:        dec.func = F_SLL;
          6'h02:        dec.func = F_SRL;
          6'h03:        dec.func = F_SRA;
          6'h04: begin dec.func = F_SLLV; dec.a = {27'b0, rs_val[4:0]}; end
          6'h06: begin dec.func = F_SRLV; dec.a = {27'b0, rs_val[4:0]}; end
          6'h07: begin dec.func = F_SRAV; dec.a = {27'b0, rs_val[4:0]}; end
          default:      dec.ill  = 1'b1;
        endcase
      end
      6'h08, 6'h09, 6'h23: begin dec.func = F_ADD;  dec.b = imm_se; end
      6'h0A:               begin dec.func = F_SLT;  dec.b = imm_se; end
      6'h0B:               begin dec.func = F_SLTU; dec.b = imm_se; end
      6'h0C:               begin dec.func = F_AND;  dec.b = imm_ze; end
      6'h0D:               begin dec.func = F_OR;   dec.b = imm_ze; end
      6'h0E:               begin dec.func = F_XOR;  dec.b = imm_ze; end
      6'h0F:               begin dec.func = F_LUI;  dec.b = imm_ze; dec.a = '0; end
      6'h2B: begin
        dec.func = F_ADD;
        dec.b    = imm_se;
        dec.dest = '0;
        dec.we   = 1'b0;
      end
      6'h04, 6'h05: begin
        dec.func = F_SUB;
        dec.dest = '0;
        dec.we   = 1'b0;
      end
      default: dec.ill = 1'b1;
    endcase
    if (dec.ill) begin
      dec.a     = '0;
      dec.b     = '0;
      dec.func  = F_ADD;
      dec.shamt = '0;
      dec.dest  = '0;
      dec.we    = 1'b0;
    end
  end

  // Next-state: flush wins, then accept (which also covers consume+accept), then consume.
  always_comb begin
    pay_d       = pay_q;
    out_valid_d = out_valid_q;
    cnt_d       = cnt_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      pay_d       = dec;
      out_valid_d = 1'b1;
      if (dec.ill && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; reset clears the payload and counter immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pay_q       <= '0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      pay_q       <= pay_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign alu_a         = pay_q.a;
  assign alu_b         = pay_q.b;
  assign alu_func      = pay_q.func;
  assign alu_shamt     = pay_q.shamt;
  assign dest_reg      = pay_q.dest;
  assign reg_write     = pay_q.we;
  assign illegal       = pay_q.ill;
  assign illegal_count = cnt_q;

endmodule

// File: tb/tb_alu_op_issue.sv
// Directed bench for alu_op_issue: decode table plus stall, flush, saturation and reset sequences.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
// The bench itself drives out_ready to exercise the stall path.
module tb_alu_op_issue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = '0;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_func;
  logic [4:0]  alu_shamt, dest_reg;
  logic        reg_write, illegal;
  logic [7:0]  illegal_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_op_issue #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs_val(rs_val), .rt_val(rt_val), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .alu_a(alu_a), .alu_b(alu_b),
    .alu_func(alu_func), .alu_shamt(alu_shamt), .dest_reg(dest_reg),
    .reg_write(reg_write), .illegal(illegal), .illegal_count(illegal_count)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  func;
    logic [4:0]  shamt;
    logic [4:0]  dest;
    logic        we;
    logic        ill;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, " out_valid"}, {31'b0, out_valid}, 32'd0);
    chk({tag, " alu_a"}, alu_a, 32'd0);
    chk({tag, " alu_b"}, alu_b, 32'd0);
    chk({tag, " alu_func"}, {28'b0, alu_func}, 32'd0);
    chk({tag, " alu_shamt"}, {27'b0, alu_shamt}, 32'd0);
    chk({tag, " dest_reg"}, {27'b0, dest_reg}, 32'd0);
    chk({tag, " reg_write"}, {31'b0, reg_write}, 32'd0);
    chk({tag, " illegal"}, {31'b0, illegal}, 32'd0);
    chk({tag, " illegal_count"}, {24'b0, illegal_count}, 32'd0);
  endtask

  initial begin
    int exp_cnt;
    logic [31:0] held_a, held_b;

    //           instr         rs            rt            a             b             func   sh     dest   we    ill
    vecs[0]  = '{32'h012A4020, 32'd5,        32'd7,        32'd5,        32'd7,        4'h0, 5'd0, 5'd8, 1'b1, 1'b0}; // add
    vecs[1]  = '{32'h2128FFFF, 32'd3,        32'd0,        32'd3,        32'hFFFFFFFF, 4'h0, 5'd0, 5'd8, 1'b1, 1'b0}; // addi -1
    vecs[2]  = '{32'h3528FFFF, 32'd3,        32'd0,        32'd3,        32'h0000FFFF, 4'h3, 5'd0, 5'd8, 1'b1, 1'b0}; // ori
    vecs[3]  = '{32'h00094083, 32'h11,       32'h80000000, 32'h11,       32'h80000000, 4'h7, 5'd2, 5'd8, 1'b1, 1'b0}; // sra 2
    vecs[4]  = '{32'h01494007, 32'h23,       32'h55,       32'd3,        32'h55,       4'hD, 5'd0, 5'd8, 1'b1, 1'b0}; // srav
    vecs[5]  = '{32'h3C081234, 32'h99,       32'd0,        32'd0,        32'h00001234, 4'hE, 5'd0, 5'd8, 1'b1, 1'b0}; // lui
    vecs[6]  = '{32'hAD090004, 32'h100,      32'h77,       32'h100,      32'd4,        4'h0, 5'd0, 5'd0, 1'b0, 1'b0}; // sw
    vecs[7]  = '{32'h11090003, 32'd10,       32'd20,       32'd10,       32'd20,       4'h1, 5'd0, 5'd0, 1'b0, 1'b0}; // beq
    vecs[8]  = '{32'h012A402A, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd1,        4'h8, 5'd0, 5'd8, 1'b1, 1'b0}; // slt
    vecs[9]  = '{32'h012A4027, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'h0F0F0F0F, 4'hA, 5'd0, 5'd8, 1'b1, 1'b0}; // nor
    vecs[10] = '{32'h2928FFFE, 32'd9,        32'd0,        32'd9,        32'hFFFFFFFE, 4'h8, 5'd0, 5'd8, 1'b1, 1'b0}; // slti
    vecs[11] = '{32'h31288000, 32'hFFFF,     32'd0,        32'hFFFF,     32'h00008000, 4'h2, 5'd0, 5'd8, 1'b1, 1'b0}; // andi ZE
    vecs[12] = '{32'h2D288000, 32'd1,        32'd0,        32'd1,        32'hFFFF8000, 4'h9, 5'd0, 5'd8, 1'b1, 1'b0}; // sltiu SE
    vecs[13] = '{32'h012A4001, 32'd5,        32'd6,        32'd0,        32'd0,        4'h0, 5'd0, 5'd0, 1'b0, 1'b1}; // illegal fn
    vecs[14] = '{32'h8D280010, 32'h200,      32'd0,        32'h200,      32'h10,       4'h0, 5'd0, 5'd8, 1'b1, 1'b0}; // lw
    vecs[15] = '{32'h01494006, 32'hFFFFFFE1, 32'h8,        32'd1,        32'h8,        4'hC, 5'd0, 5'd8, 1'b1, 1'b0}; // srlv

    // Reset state, including ready while held in reset.
    #2;
    chk_zero_outputs("reset");
    chk("reset in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: back-to-back issue with the ALU always ready.
    exp_cnt = 0;
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      instr    = vecs[i].instr;
      rs_val   = vecs[i].rs;
      rt_val   = vecs[i].rt;
      @(posedge clk);
      #1;
      if (vecs[i].ill) exp_cnt++;
      chk($sformatf("v%0d out_valid", i), {31'b0, out_valid}, 32'd1);
      chk($sformatf("v%0d alu_a", i), alu_a, vecs[i].a);
      chk($sformatf("v%0d alu_b", i), alu_b, vecs[i].b);
      chk($sformatf("v%0d alu_func", i), {28'b0, alu_func}, {28'b0, vecs[i].func});
      chk($sformatf("v%0d alu_shamt", i), {27'b0, alu_shamt}, {27'b0, vecs[i].shamt});
      chk($sformatf("v%0d dest_reg", i), {27'b0, dest_reg}, {27'b0, vecs[i].dest});
      chk($sformatf("v%0d reg_write", i), {31'b0, reg_write}, {31'b0, vecs[i].we});
      chk($sformatf("v%0d illegal", i), {31'b0, illegal}, {31'b0, vecs[i].ill});
      chk($sformatf("v%0d illegal_count", i), {24'b0, illegal_count}, exp_cnt);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("drain out_valid", {31'b0, out_valid}, 32'd0);

    // Stall: A held for 3 cycles while B waits, then B follows with no bubble.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr     = 32'h012A4022; // sub
    rs_val    = 32'hAAAA0001;
    rt_val    = 32'h00000011;
    @(posedge clk);
    #1;
    chk("stall A valid", {31'b0, out_valid}, 32'd1);
    chk("stall A func", {28'b0, alu_func}, 32'd1);
    held_a = alu_a;
    held_b = alu_b;
    chk("stall A alu_a", held_a, 32'hAAAA0001);
    @(negedge clk);
    instr  = 32'h012A4024; // and
    rs_val = 32'hBBBB0002;
    rt_val = 32'h00000022;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("stall%0d in_ready", c), {31'b0, in_ready}, 32'd0);
      chk($sformatf("stall%0d out_valid", c), {31'b0, out_valid}, 32'd1);
      chk($sformatf("stall%0d alu_a", c), alu_a, 32'hAAAA0001);
      chk($sformatf("stall%0d alu_b", c), alu_b, 32'h00000011);
      chk($sformatf("stall%0d alu_func", c), {28'b0, alu_func}, 32'd1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("release in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    chk("B out_valid", {31'b0, out_valid}, 32'd1);
    chk("B alu_a", alu_a, 32'hBBBB0002);
    chk("B alu_b", alu_b, 32'h00000022);
    chk("B alu_func", {28'b0, alu_func}, 32'd2);

    // Flush beats an incoming illegal instruction while a payload is held.
    @(negedge clk);
    instr = 32'hFC000000;
    flush = 1'b1;
    @(posedge clk);
    #1;
    chk("flush out_valid", {31'b0, out_valid}, 32'd0);
    chk("flush illegal_count", {24'b0, illegal_count}, exp_cnt);
    @(negedge clk);
    flush = 1'b0;
    @(posedge clk);
    #1;
    exp_cnt++;
    chk("ill out_valid", {31'b0, out_valid}, 32'd1);
    chk("ill illegal", {31'b0, illegal}, 32'd1);
    chk("ill reg_write", {31'b0, reg_write}, 32'd0);
    chk("ill alu_func", {28'b0, alu_func}, 32'd0);
    chk("ill illegal_count", {24'b0, illegal_count}, exp_cnt);

    // Saturation: 256 more illegal accepts must pin the counter at 0xFF.
    for (int k = 0; k < 256; k++) begin
      @(posedge clk);
      #1;
      exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
      if (k == 250 || k == 253 || k == 255)
        chk($sformatf("sat%0d illegal_count", k), {24'b0, illegal_count}, exp_cnt);
    end
    chk("sat final", {24'b0, illegal_count}, 32'hFF);

    // Reset in the middle of a stall clears everything without a clock edge.
    @(negedge clk);
    out_ready = 1'b0;
    instr     = 32'h012A4020;
    rs_val    = 32'd1;
    rt_val    = 32'd2;
    @(posedge clk);
    #1;
    chk("pre-rst out_valid", {31'b0, out_valid}, 32'd1);
    chk("pre-rst in_ready", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("midrst");
    chk("midrst in_ready", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post-rst out_valid", {31'b0, out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
